// File: rtl/uart_word_rx_fifo.sv
// uart_word_rx_fifo
//   UART (8N1) receive front-end. Deserialises the serial line, packs bytes
//   into WORD_SIZE-bit words (byte order chosen per word by msb_first),
//   flushes a zero-padded partial word after TIMEOUT_BITS idle bit periods,
//   and buffers {partial, word} entries in a show-ahead FIFO.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   sig          serial line, idle high (synchronised internally)
//   msb_first    byte order for the next word (0: first byte in [7:0])
//   read_req     pop the head word (ignored while empty)
//   clear_flags  clear the sticky overflow flag
//   data_out     head word, 0 when empty
//   partial_out  head word came from a timeout flush
//   full/empty   FIFO occupancy flags
//   level        current word count
//   overflow     sticky: a word was dropped because the FIFO was full
//   frame_err    one-cycle pulse when a stop bit is sampled low
module uart_word_rx_fifo #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned CLK_FREQ     = 200_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sig,
    input  logic                     msb_first,
    input  logic                     read_req,
    input  logic                     clear_flags,
    output logic [WORD_SIZE-1:0]     data_out,
    output logic                     partial_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned BYTES        = WORD_SIZE / 8;
    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BC_W         = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned AW           = $clog2(DEPTH);
    localparam int unsigned CW           = AW + 1;

    // ------------------------------------------------------------------
    // Line synchroniser (resets to idle-high so reset never looks like a start bit)
    // ------------------------------------------------------------------
    logic sig_meta;
    logic sig_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_meta <= 1'b1;
            sig_sync <= 1'b1;
        end else begin
            sig_meta <= sig;
            sig_sync <= sig_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    rx_state_t        rx_state, rx_state_nx;
    logic [CNT_W-1:0] bit_cnt,  bit_cnt_nx;
    logic [2:0]       bit_idx,  bit_idx_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic             byte_stb, byte_stb_nx;
    logic             frame_err_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_nx;
            bit_cnt   <= bit_cnt_nx;
            bit_idx   <= bit_idx_nx;
            rx_shift  <= rx_shift_nx;
            byte_stb  <= byte_stb_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        rx_state_nx  = rx_state;
        bit_cnt_nx   = bit_cnt;
        bit_idx_nx   = bit_idx;
        rx_shift_nx  = rx_shift;
        byte_stb_nx  = 1'b0;
        frame_err_nx = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!sig_sync) begin
                    rx_state_nx = RX_START;
                    bit_cnt_nx  = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit resample rejects short glitches.
                if (bit_cnt == CNT_W'(HALF_BIT - 1)) begin
                    bit_cnt_nx  = '0;
                    bit_idx_nx  = '0;
                    rx_state_nx = sig_sync ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_nx  = '0;
                    rx_shift_nx = {sig_sync, rx_shift[7:1]};
                    bit_idx_nx  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nx = RX_STOP;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_nx = '0;
                    if (sig_sync) begin
                        byte_stb_nx = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        rx_state_nx  = RX_BREAK;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (sig_sync) begin
                    rx_state_nx = RX_IDLE;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word assembler with idle-timeout flush
    // ------------------------------------------------------------------
    logic [BC_W-1:0]      byte_cnt;
    logic [WORD_SIZE-1:0] word_buf;
    logic                 order_q;
    logic [31:0]          idle_cnt;
    logic                 push_valid;
    logic                 push_partial;
    logic [WORD_SIZE-1:0] push_word;

    logic                 first_byte;
    logic                 last_byte;
    logic                 order_eff;
    logic [BC_W-1:0]      slot;
    logic [WORD_SIZE-1:0] merged;
    logic                 timeout_hit;

    always_comb begin
        first_byte  = (byte_cnt == '0);
        last_byte   = (byte_cnt == BC_W'(BYTES - 1));
        // The order for byte 0 comes straight from the pin; later bytes use the latched copy.
        order_eff   = first_byte ? msb_first : order_q;
        slot        = order_eff ? (BC_W'(BYTES - 1) - byte_cnt) : byte_cnt;
        // Each word starts from zero so a flushed partial word is zero-padded.
        merged      = (first_byte ? '0 : word_buf) | (WORD_SIZE'(rx_shift) << {slot, 3'b000});
        timeout_hit = (TIMEOUT_BITS != 0) && !first_byte && (idle_cnt == TIMEOUT_CLKS - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            order_q      <= 1'b0;
            idle_cnt     <= '0;
            push_valid   <= 1'b0;
            push_partial <= 1'b0;
            push_word    <= '0;
        end else begin
            push_valid   <= 1'b0;
            push_partial <= 1'b0;
            if (byte_stb) begin
                idle_cnt <= '0;
                if (first_byte) begin
                    order_q <= msb_first;
                end
                if (last_byte) begin
                    push_valid <= 1'b1;
                    push_word  <= merged;
                    byte_cnt   <= '0;
                end else begin
                    word_buf <= merged;
                    byte_cnt <= byte_cnt + BC_W'(1);
                end
            end else if (timeout_hit) begin
                push_valid   <= 1'b1;
                push_partial <= 1'b1;
                push_word    <= word_buf;
                byte_cnt     <= '0;
                idle_cnt     <= '0;
            end else if (!first_byte) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO of {partial, word}
    // ------------------------------------------------------------------
    logic [WORD_SIZE:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;
    logic               reject;

    always_comb begin
        do_pop  = read_req && (count != '0);
        // A full FIFO still accepts a push when the head is popped in the same cycle.
        do_push = push_valid && ((count != CW'(DEPTH)) || read_req);
        reject  = push_valid && !do_push;
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_partial, push_word};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as clear_flags wins.
            if (reject) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    assign level       = count;
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign data_out    = empty ? '0 : mem[rd_ptr][WORD_SIZE-1:0];
    assign partial_out = !empty && mem[rd_ptr][WORD_SIZE];

endmodule

// File: tb/tb_uart_word_rx_fifo.sv
// tb_uart_word_rx_fifo
//   Self-checking bench for uart_word_rx_fifo (10 clocks/bit, 32-bit words,
//   4-deep FIFO, 20-bit timeout). A queue-based reference model tracks the
//   pending bytes of the current word and the FIFO contents.
module tb_uart_word_rx_fifo;

    localparam int CPB   = 10;
    localparam int BYTES = 4;
    localparam int DEP   = 4;

    logic        clock;
    logic        reset;
    logic        sig;
    logic        msb_first;
    logic        read_req;
    logic        clear_flags;
    logic [31:0] data_out;
    logic        partial_out;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        overflow;
    logic        frame_err;

    uart_word_rx_fifo #(
        .WORD_SIZE    (32),
        .DEPTH        (DEP),
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .TIMEOUT_BITS (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .msb_first   (msb_first),
        .read_req    (read_req),
        .clear_flags (clear_flags),
        .data_out    (data_out),
        .partial_out (partial_out),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_pulses = 0;

    always @(negedge clock) if (frame_err) fe_pulses++;

    // ---------------- reference model ----------------
    logic [32:0] mq[$];
    logic [7:0]  pend[$];
    bit          m_order;
    bit          m_ovf;

    function automatic logic [31:0] pack_pending();
        logic [31:0] w;
        int pos;
        w = '0;
        for (int i = 0; i < pend.size(); i++) begin
            pos = m_order ? (BYTES - 1 - i) : i;
            w = w | (32'(pend[i]) << (8 * pos));
        end
        return w;
    endfunction

    task automatic model_push(input logic [31:0] w, input bit p, input bit rd);
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEP) mq.push_back({p, w});
        else m_ovf = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit rd);
        if (pend.size() == 0) m_order = msb_first;
        pend.push_back(b);
        if (pend.size() == BYTES) begin
            model_push(pack_pending(), 1'b0, rd);
            pend.delete();
        end else if (rd && mq.size() > 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic model_flush();
        if (pend.size() > 0) begin
            model_push(pack_pending(), 1'b1, 1'b0);
            pend.delete();
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [32:0] head;
        head = (mq.size() > 0) ? mq[0] : 33'd0;
        check({tag, ".data"},    data_out,    head[31:0]);
        check({tag, ".partial"}, partial_out, head[32]);
        check({tag, ".level"},   level,       mq.size());
        check({tag, ".full"},    full,        mq.size() == DEP);
        check({tag, ".empty"},   empty,       mq.size() == 0);
        check({tag, ".ovf"},     overflow,    m_ovf);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] pre_level;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One 8N1 frame. A word completed by this frame reaches the FIFO two clocks
    // after the stop-bit sample: 2 sync flops + 1 detect clock + CPB/2 + 9*CPB
    // + 2 = clock 100 after the start bit is driven, i.e. the last clock here.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit rd);
        sig = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            sig = b[i];
            tick(CPB);
        end
        sig = stop;
        tick(CPB - 1);
        pre_level = level;
        read_req  = rd;
        tick(1);
        read_req  = 1'b0;
        sig = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rd);
        send_frame(b, 1'b1, rd);
        model_byte(b, rd);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rd);
        for (int i = 0; i < BYTES; i++) send_byte(w[8*i +: 8], (i == BYTES - 1) ? rd : 1'b0);
    endtask

    task automatic pop_word(input string tag);
        read_req = 1'b1;
        tick(1);
        read_req = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        mq.delete();
        pend.delete();
        m_ovf = 1'b0;
        check("rst.data",    data_out,    32'd0);
        check("rst.partial", partial_out, 1'b0);
        check("rst.full",    full,        1'b0);
        check("rst.empty",   empty,       1'b1);
        check("rst.level",   level,       3'd0);
        check("rst.ovf",     overflow,    1'b0);
        check("rst.ferr",    frame_err,   1'b0);
        sig = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fe0;
        int nb;
        logic [31:0] w;
        sig = 1'b1; msb_first = 1'b0; read_req = 1'b0; clear_flags = 1'b0;
        reset = 1'b0;
        m_order = 1'b0; m_ovf = 1'b0;
        tick(1);
        do_reset();

        // LSB-first word, push timing
        msb_first = 1'b0;
        send_word(32'h44332211, 1'b0);
        check("lsb.pre_level", pre_level, 3'd0);
        check("lsb.word", data_out, 32'h44332211);
        check_all("lsb");
        pop_word("lsb.pop");

        // MSB-first word; msb_first toggled mid-word is ignored
        msb_first = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        msb_first = 1'b0;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("msb.word", data_out, 32'h11223344);
        check_all("msb");
        pop_word("msb.pop");

        // Partial-word timeout flush
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        tick(150);
        check("tmo.early_level", level, 3'd0);
        tick(100);
        model_flush();
        check("tmo.word", data_out, 32'h0000BBAA);
        check("tmo.partial", partial_out, 1'b1);
        send_word(32'h04030201, 1'b0);
        check_all("tmo.next");
        pop_word("tmo.pop1");
        check("tmo.full_word_partial", partial_out, 1'b0);
        pop_word("tmo.pop2");

        // Overflow and push-with-pop while full
        for (int i = 0; i < DEP; i++) send_word($urandom, 1'b0);
        check("ovf.full", full, 1'b1);
        send_word($urandom, 1'b0);
        check("ovf.flag", overflow, 1'b1);
        check_all("ovf.drop");
        send_word($urandom, 1'b1);
        check("ovf.pushpop_level", level, 3'd4);
        check_all("ovf.pushpop");
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        m_ovf = 1'b0;
        check_all("ovf.clear");
        for (int i = 0; i < DEP; i++) pop_word("ovf.drain");

        // Framing error then glitch
        fe0 = fe_pulses;
        send_frame(8'h55, 1'b0, 1'b0);
        sig = 1'b0;
        tick(40);
        check("ferr.pulses", fe_pulses - fe0, 1);
        sig = 1'b1;
        tick(300);
        check_all("ferr.nobyte");
        sig = 1'b0;
        tick(3);
        sig = 1'b1;
        tick(300);
        check("glitch.pulses", fe_pulses - fe0, 1);
        check_all("glitch");
        msb_first = 1'($urandom);
        send_word($urandom, 1'b0);
        check_all("ferr.after");
        pop_word("ferr.pop");

        // Randomised traffic
        for (int it = 0; it < 10; it++) begin
            msb_first = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(1, BYTES - 1);
                for (int i = 0; i < nb; i++) begin
                    send_byte(8'($urandom), 1'b0);
                    tick($urandom_range(0, 40));
                end
                tick(260);
                model_flush();
            end else begin
                for (int i = 0; i < BYTES; i++) begin
                    send_byte(8'($urandom), (i == BYTES - 1) ? 1'($urandom) : 1'b0);
                    if (i != BYTES - 1) tick($urandom_range(0, 40));
                end
            end
            check_all("rand.word");
            if ($urandom_range(0, 1) == 1) pop_word("rand.pop");
        end
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        m_ovf = 1'b0;
        for (int i = 0; i < DEP; i++) pop_word("rand.drain");

        // Reset mid-word and mid-frame
        msb_first = 1'b0;
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        check("rstmid.level", level, 3'd2);
        send_byte(8'h77, 1'b0);
        sig = 1'b0;
        tick(CPB);
        sig = 1'b1;
        tick(CPB);
        sig = 1'b0;
        tick(CPB);
        do_reset();
        tick(300);
        check_all("rstmid.noflush");
        send_word(32'hEFBEADDE, 1'b0);
        check("rstmid.word", data_out, 32'hEFBEADDE);
        check("rstmid.level1", level, 3'd1);
        check_all("rstmid.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_rx_fifo.md
# uart_word_rx_fifo

Parametrised UART receive front-end: deserialises an 8N1 serial line, packs received bytes into WORD_SIZE-bit words with selectable byte order, flushes zero-padded partial words after a configurable idle timeout, and buffers words in a show-ahead FIFO. It is the generalised successor of the fixed 8→32, 64-deep UART input path. It adds:
- configurable width and depth;
- byte-order mode;
- partial-word flush;
- framing-error and overflow reporting.

## Interface
- WORD_SIZE, 32, output word width; must be a multiple of 8, at least 8
- DEPTH, 64, FIFO depth in words; must be a power of 2, at least 2
- CLK_FREQ, 200_000_000, clock frequency in Hz
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be at least 4
- TIMEOUT_BITS, 32, idle bit periods before a partial word is flushed; 0 disables flushing
- clock  in  1  single clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sig  in  1  serial line, idle high; synchronised internally with 2 flops
- msb_first  in  1  0: first byte goes to bits [7:0]; 1: first byte goes to the top byte
- read_req  in  1  pop head word; ignored while empty
- clear_flags  in  1  clears the overflow flag
- data_out  out  WORD_SIZE  head word (show-ahead); 0 when empty
- partial_out  out  1  head word was a timeout flush
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- level  out  $clog2(DEPTH)+1  current word count
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low

## Operation
- Reset values: data_out=0, partial_out=0, full=0, empty=1, level=0, overflow=0, frame_err=0; receiver in IDLE; byte count 0.
- Receiver states:
  - IDLE: on synced sig=0, go to START.
  - START: after CLKS_PER_BIT/2 clocks, resample; if sig=1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT clocks apart; then go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks. If 1, issue a byte strobe and go to IDLE. If 0, pulse frame_err, discard the byte and go to BREAK.
  - BREAK: wait for synced sig=1, then go to IDLE.
- Assembler:
  - BYTES = WORD_SIZE/8; byte count runs 0..BYTES-1.
  - msb_first is latched when a byte arrives with byte count 0; changes mid-word have no effect until the next word.
  - When byte count reaches BYTES, the word is pushed with partial=0 and byte count returns to 0.
- Timeout flush:
  - Idle counter resets on every byte strobe and counts only while byte count is nonzero.
  - At TIMEOUT_BITS*CLKS_PER_BIT clocks, push the word with unfilled bytes = 0 and partial=1; byte count returns to 0.
- FIFO: stores {partial, word}.
  - Write is accepted if !full, or if full and read_req is high in the same cycle (simultaneous push/pop keeps level unchanged).
  - A rejected write sets overflow; the word is lost.
  - Read while empty: no effect.
  - Pointers wrap modulo DEPTH.
- Flags: overflow clears only on clear_flags or reset. If clear_flags and a rejected write occur in the same cycle, overflow stays 1.
- A frame error does not affect the assembler's byte count or idle counter.

## Timing
- Byte strobe is registered in cycle T, the stop-bit sample cycle.
- The assembler push strobe is registered in T+1.
- FIFO state updates at T+2: empty falls, level increments and data_out is valid at T+2.
- Pop: data_out, level, full and empty update in the cycle after read_req.
- frame_err is high for exactly the cycle after the low stop-bit sample.
- Timeout push follows the same one-cycle registration to the FIFO as a normal push.
- Reset asserted mid-frame or mid-word aborts it immediately. The partial word is discarded, not flushed. Outputs hold reset values until the next clock after reset is released.

## Test plan
Use CLK_FREQ=1_000_000, BAUD=100_000 (10 clocks/bit), WORD_SIZE=32, DEPTH=4, TIMEOUT_BITS=20.
- Bytes 0x11,0x22,0x33,0x44 with msb_first=0 → data_out=0x44332211, partial_out=0, level=1, empty=0 exactly 2 cycles after the 4th stop sample.
- Same bytes with msb_first=1 → data_out=0x11223344; toggling msb_first after byte 2 has no effect on this word.
- Bytes 0xAA,0xBB, then line idle for 200 clocks → data_out=0x0000BBAA, partial_out=1. The next 4 bytes form a full word with partial_out=0.
- Push 4 words (full=1), then send a 5th → overflow=1, level=4, head unchanged. A 6th word arriving with read_req high in the push cycle is accepted, level stays 4. clear_flags → overflow=0.
- Frame with stop bit 0 (byte 0x55) → one frame_err pulse, no byte counted, BREAK until sig=1. A 3-clock low glitch → no byte, no frame_err.
- Reset asserted mid-DATA after 2 buffered words → all outputs at reset values. A following clean 4-byte sequence 0xDE,0xAD,0xBE,0xEF → 0xEFBEADDE, level=1.
